alarm_sequencer: RTL

//  Control stage directly upstream of the audio block: decides when alarm_on is high.

---
 rtl/alarm_sequencer_if.sv | 31 +++
 rtl/alarm_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/alarm_sequencer_if.sv
// Signal bundle between the alarm sequencer, the time/keypad/math side and the audio block.
interface alarm_sequencer_if;
    logic       sec_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic [4:0] alm_hour;
    logic [5:0] alm_min;
    logic       alarm_enable;
    logic       snooze_req;
    logic       answer_valid;
    logic       answer_correct;
    logic       alarm_on;
    logic       snoozing;
    logic       new_problem;
    logic       dismissed;
    logic [2:0] snooze_used;
    logic [3:0] wrong_count;

    modport master (
        output sec_tick, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
               alarm_enable, snooze_req, answer_valid, answer_correct,
        input  alarm_on, snoozing, new_problem, dismissed, snooze_used, wrong_count
    );

    modport slave (
        input  sec_tick, cur_hour, cur_min, cur_sec, alm_hour, alm_min,
               alarm_enable, snooze_req, answer_valid, answer_correct,
        output alarm_on, snoozing, new_problem, dismissed, snooze_used, wrong_count
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Alarm ring/snooze sequencer: decides when the audio block sounds and tracks
// snoozes and wrong math answers for the current alarm event.
module alarm_sequencer #(
    parameter int SNOOZE_S       = 300,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3,
    parameter int CNT_W          = 9
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    alarm_sequencer_if.slave  io
);
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             alarm_on_q, snoozing_q, new_problem_q, dismissed_q;
    logic [2:0]       snooze_used_q;
    logic [3:0]       wrong_count_q;
    logic             trig, correct, wrong, expiry, budget;

    assign trig    = io.sec_tick & io.alarm_enable & (io.cur_sec == 6'd0) &
                     (io.cur_hour == io.alm_hour) & (io.cur_min == io.alm_min);
    assign correct = io.answer_valid & io.answer_correct;
    assign wrong   = io.answer_valid & ~io.answer_correct;
    assign expiry  = io.sec_tick & (cnt == CNT_W'(1));
    assign budget  = snooze_used_q < 3'(MAX_SNOOZE);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            alarm_on_q    <= 1'b0;
            snoozing_q    <= 1'b0;
            new_problem_q <= 1'b0;
            dismissed_q   <= 1'b0;
            snooze_used_q <= '0;
            wrong_count_q <= '0;
        end else begin
            new_problem_q <= 1'b0;
            dismissed_q   <= 1'b0;
            // Disable wins over everything; event counters are left for inspection.
            if (!io.alarm_enable) begin
                state      <= IDLE;
                alarm_on_q <= 1'b0;
                snoozing_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (trig) begin
                            state         <= RINGING;
                            alarm_on_q    <= 1'b1;
                            cnt           <= CNT_W'(RING_TIMEOUT_S);
                            snooze_used_q <= '0;
                            wrong_count_q <= '0;
                            new_problem_q <= 1'b1;
                        end
                    end
                    RINGING: begin
                        if (correct) begin
                            state       <= IDLE;
                            alarm_on_q  <= 1'b0;
                            dismissed_q <= 1'b1;
                        end else begin
                            if (wrong && wrong_count_q != 4'hF)
                                wrong_count_q <= wrong_count_q + 4'd1;
                            // Manual snooze and expiry in the same cycle consume one snooze.
                            if ((io.snooze_req || expiry) && budget) begin
                                state         <= SNOOZE;
                                alarm_on_q    <= 1'b0;
                                snoozing_q    <= 1'b1;
                                snooze_used_q <= snooze_used_q + 3'd1;
                                cnt           <= CNT_W'(SNOOZE_S);
                            end else if (wrong || expiry) begin
                                cnt <= CNT_W'(RING_TIMEOUT_S);
                            end else if (io.sec_tick) begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
                    SNOOZE: begin
                        if (correct) begin
                            state       <= IDLE;
                            snoozing_q  <= 1'b0;
                            dismissed_q <= 1'b1;
                        end else begin
                            if (wrong && wrong_count_q != 4'hF)
                                wrong_count_q <= wrong_count_q + 4'd1;
                            // Back to ringing keeps the same problem, so no new_problem here.
                            if (expiry) begin
                                state      <= RINGING;
                                alarm_on_q <= 1'b1;
                                snoozing_q <= 1'b0;
                                cnt        <= CNT_W'(RING_TIMEOUT_S);
                            end else if (io.sec_tick) begin
                                cnt <= cnt - CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        alarm_on_q <= 1'b0;
                        snoozing_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.alarm_on    = alarm_on_q;
    assign io.snoozing    = snoozing_q;
    assign io.new_problem = new_problem_q;
    assign io.dismissed   = dismissed_q;
    assign io.snooze_used = snooze_used_q;
    assign io.wrong_count = wrong_count_q;
endmodule
